// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the punctured convolutional encoder.
//   Rate codes, default generator masks, puncture periods and keep masks,
//   and the tail-sequencer state type used when CONV_TAIL_EN is defined.
package conv_pkg;

   localparam logic [1:0] RATE_1_2 = 2'b00;
   localparam logic [1:0] RATE_2_3 = 2'b01;
   localparam logic [1:0] RATE_3_4 = 2'b10;

   localparam int unsigned K_DEFAULT  = 7;
   localparam logic [6:0]  G0_DEFAULT = 7'b1011011;
   localparam logic [6:0]  G1_DEFAULT = 7'b1111001;

   localparam logic [1:0] PERIOD_1_2 = 2'd1;
   localparam logic [1:0] PERIOD_2_3 = 2'd2;
   localparam logic [1:0] PERIOD_3_4 = 2'd3;

   // Keep masks as {keep_b, keep_a}; A is always emitted before B.
   localparam logic [1:0] KEEP_AB = 2'b11;
   localparam logic [1:0] KEEP_A  = 2'b01;
   localparam logic [1:0] KEEP_B  = 2'b10;

   typedef enum logic {StIdle, StTail} tail_st_e;

   // The reserved code behaves as rate 1/2.
   function automatic logic [1:0] norm_rate(input logic [1:0] rate);
      return (rate == RATE_2_3 || rate == RATE_3_4) ? rate : RATE_1_2;
   endfunction

   function automatic logic [1:0] punct_period(input logic [1:0] rate);
      unique case (rate)
         RATE_2_3: return PERIOD_2_3;
         RATE_3_4: return PERIOD_3_4;
         default:  return PERIOD_1_2;
      endcase
   endfunction

   function automatic logic [1:0] punct_keep(input logic [1:0] rate, input logic [1:0] phase);
      if (phase == 2'd0) return KEEP_AB;
      if (rate == RATE_3_4 && phase == 2'd2) return KEEP_B;
      return KEEP_A;
   endfunction

endpackage

// File: rtl/conv_parity.sv
// conv_parity: K-1 bit shift register plus the two generator parities.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (state <= INITIAL_STATE)
//   init_i  : treat the register as INITIAL_STATE for this bit (frame start)
//   shift_i : commit data_i into the shift register
//   data_i  : current input bit
//   a_o/b_o : generator A/B outputs for {data_i, state}
module conv_parity
   import conv_pkg::*;
#(
   parameter int unsigned      K             = K_DEFAULT,
   parameter logic [K-1:0]     G0            = G0_DEFAULT,
   parameter logic [K-1:0]     G1            = G1_DEFAULT,
   parameter logic [K-2:0]     INITIAL_STATE = '0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic init_i,
   input  logic shift_i,
   input  logic data_i,
   output logic a_o,
   output logic b_o
);

   logic [K-2:0] state_q, state_d, base;
   logic [K-1:0] vec;

   always_comb begin
      base    = init_i ? INITIAL_STATE : state_q;
      vec     = {data_i, base};
      a_o     = ^(G0 & vec);
      b_o     = ^(G1 & vec);
      // Newest bit enters at the top, oldest falls off the bottom.
      state_d = shift_i ? vec[K-1:1] : state_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= INITIAL_STATE;
      else       state_q <= state_d;
   end

endmodule

// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: convolutional encoder with rate 1/2, 2/3, 3/4 puncturing.
//   clk_i, rst_i      : clock and synchronous active-high reset
//   rate_i            : coding rate, latched on an accepted frame-start bit
//   frame_start_i     : in_data_i is the first bit of a frame
//   in_valid_i/in_ready_o, in_data_i    : input bit stream
//   out_valid_o/out_ready_i, out_data_o : punctured coded bit stream
//   tail_req_i/tail_done_o (only with CONV_TAIL_EN): inject K-1 zero tail bits
module conv_encoder_punct
   import conv_pkg::*;
#(
   parameter int unsigned      K             = K_DEFAULT,
   parameter logic [K-1:0]     G0            = G0_DEFAULT,
   parameter logic [K-1:0]     G1            = G1_DEFAULT,
   parameter logic [K-2:0]     INITIAL_STATE = '0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] rate_i,
   input  logic       frame_start_i,
   input  logic       in_valid_i,
   input  logic       in_data_i,
   output logic       in_ready_o,
   output logic       out_valid_o,
   output logic       out_data_o,
   input  logic       out_ready_i
`ifdef CONV_TAIL_EN
   ,
   input  logic       tail_req_i,
   output logic       tail_done_o
`endif
);

   logic [1:0] cnt_q, cnt_d;      // pending bits, 0..2
   logic [1:0] buf_q, buf_d;      // pending bits, oldest in bit 0
   logic [1:0] rate_q, rate_d;
   logic [1:0] phase_q, phase_d;

   logic       space, pop, push, push_data, push_init;
   logic       a, b;
   logic [1:0] rate_cur, phase_cur, keep, phase_inc;

   // A new bit may enter when the buffer is empty or its last bit leaves now.
   assign space = (cnt_q == 2'd0) || (cnt_q == 2'd1 && out_ready_i);
   assign pop   = (cnt_q != 2'd0) && out_ready_i;

`ifdef CONV_TAIL_EN
   localparam int unsigned TW = $clog2(K);

   tail_st_e      st_q, st_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          inject;

   assign in_ready_o = space && (st_q == StIdle) && !tail_req_i;
   assign inject     = (st_q == StTail) && (tcnt_q != '0) && space;
   assign push       = (in_valid_i && in_ready_o) || inject;
   assign push_data  = !inject && in_data_i;
   assign push_init  = !inject && frame_start_i;

   always_comb begin
      st_d        = st_q;
      tcnt_d      = tcnt_q;
      tail_done_o = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (tail_req_i && cnt_q == 2'd0) begin
               st_d   = StTail;
               tcnt_d = TW'(K - 1);
            end
         end
         StTail: begin
            if (inject) tcnt_d = tcnt_q - 1'b1;
            // All zeros injected; the final pending bit leaves this cycle.
            if (tcnt_q == '0 && cnt_q == 2'd1 && out_ready_i) begin
               tail_done_o = 1'b1;
               st_d        = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q   <= StIdle;
         tcnt_q <= '0;
      end else begin
         st_q   <= st_d;
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign in_ready_o = space;
   assign push       = in_valid_i && space;
   assign push_data  = in_data_i;
   assign push_init  = frame_start_i;
`endif

   conv_parity #(
      .K             (K),
      .G0            (G0),
      .G1            (G1),
      .INITIAL_STATE (INITIAL_STATE)
   ) u_parity (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .init_i  (push_init),
      .shift_i (push),
      .data_i  (push_data),
      .a_o     (a),
      .b_o     (b)
   );

   always_comb begin
      rate_cur  = push_init ? norm_rate(rate_i) : rate_q;
      phase_cur = push_init ? 2'd0 : phase_q;
      keep      = punct_keep(rate_cur, phase_cur);
      phase_inc = phase_cur + 2'd1;

      cnt_d   = cnt_q;
      buf_d   = buf_q;
      rate_d  = rate_q;
      phase_d = phase_q;
      if (push) begin
         // Any earlier pending bit is popped this same cycle, so just reload.
         rate_d  = rate_cur;
         phase_d = (phase_inc == punct_period(rate_cur)) ? 2'd0 : phase_inc;
         unique case (keep)
            KEEP_AB: begin buf_d = {b, a};    cnt_d = 2'd2; end
            KEEP_A:  begin buf_d = {1'b0, a}; cnt_d = 2'd1; end
            default: begin buf_d = {1'b0, b}; cnt_d = 2'd1; end
         endcase
      end else if (pop) begin
         buf_d = {1'b0, buf_q[1]};
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= 2'd0;
         buf_q   <= 2'b00;
         rate_q  <= RATE_1_2;
         phase_q <= 2'd0;
      end else begin
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         rate_q  <= rate_d;
         phase_q <= phase_d;
      end
   end

   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = out_valid_o && buf_q[0];

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Testbench for conv_encoder_punct (default build, tail feature disabled).
module tb_conv_encoder_punct;

   logic       clk = 1'b0;
   logic       rst, frame_start, in_valid, in_data, in_ready;
   logic       out_valid, out_data, out_ready;
   logic [1:0] rate;

   always #5 clk = ~clk;

   conv_encoder_punct dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rate_i        (rate),
      .frame_start_i (frame_start),
      .in_valid_i    (in_valid),
      .in_data_i     (in_data),
      .in_ready_o    (in_ready),
      .out_valid_o   (out_valid),
      .out_data_o    (out_data),
      .out_ready_i   (out_ready)
   );

   typedef struct {
      bit         d;
      bit         fs;
      logic [1:0] r;
   } ib_t;

   localparam logic [6:0] GA = 7'b1011011;
   localparam logic [6:0] GB = 7'b1111001;

   ib_t src[$];   // bits waiting to be offered
   bit  pend[$];  // coded bits the DUT should still emit, oldest first
   bit  got[$];   // coded bits the DUT emitted
   bit  hist[6];  // past inputs, hist[0] newest
   int  m_rate, m_ph;
   int  total = 0, bad = 0;

   // Keep tables indexed [rate][phase].
   bit keep_a_t[3][3] = '{'{1, 0, 0}, '{1, 1, 0}, '{1, 1, 0}};
   bit keep_b_t[3][3] = '{'{1, 0, 0}, '{1, 0, 0}, '{1, 0, 1}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_accept(input bit d, input bit fs, input logic [1:0] r);
      bit a, b;
      if (fs) begin
         foreach (hist[i]) hist[i] = 1'b0;
         m_ph   = 0;
         m_rate = (r == 2'b11) ? 0 : int'(r);
      end
      // Tap j (0 = current input, j = input j bits ago) uses generator bit 6-j.
      a = d & GA[6];
      b = d & GB[6];
      for (int j = 1; j < 7; j++) begin
         a ^= hist[j-1] & GA[6-j];
         b ^= hist[j-1] & GB[6-j];
      end
      for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = d;
      if (keep_a_t[m_rate][m_ph]) pend.push_back(a);
      if (keep_b_t[m_rate][m_ph]) pend.push_back(b);
      m_ph = (m_ph + 1) % (m_rate + 1);
   endfunction

   task automatic push_bit(input bit d, input bit fs, input logic [1:0] r);
      ib_t e;
      e.d  = d;
      e.fs = fs;
      e.r  = r;
      src.push_back(e);
   endtask

   task automatic load_bits(input logic [1:0] r, input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) push_bit(pat[n-1-i], i == 0, r);
   endtask

   task automatic step(input bit vin, input bit rdy);
      bit exp_rdy;
      in_valid = vin && (src.size() != 0);
      if (in_valid) begin
         in_data     = src[0].d;
         frame_start = src[0].fs;
         rate        = src[0].r;
      end else begin
         in_data     = 1'($urandom);
         frame_start = 1'($urandom);
         rate        = 2'($urandom);
      end
      out_ready = rdy;
      @(negedge clk);
      exp_rdy = (pend.size() == 0) || (pend.size() == 1 && rdy);
      chk("out_valid", 32'(out_valid), 32'(pend.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (pend.size() != 0) chk("out_data", 32'(out_data), 32'(pend[0]));
      if (out_valid && rdy) begin
         got.push_back(out_data);
         if (pend.size() != 0) void'(pend.pop_front());
      end
      if (in_valid && in_ready) begin
         model_accept(src[0].d, src[0].fs, src[0].r);
         void'(src.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit rnd, input int budget);
      int c = 0;
      while ((src.size() != 0 || pend.size() != 0) && c < budget) begin
         if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
         else     step(1'b1, 1'b1);
         c++;
      end
      chk("drain_left", 32'(src.size() + pend.size()), 32'd0);
   endtask

   task automatic compare_got(input string tag, input logic [31:0] pat, input int n);
      chk({tag, "_len"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(pat[n-1-i]));
      got.delete();
   endtask

   initial begin
      int n;
      logic [1:0] r;
      rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; frame_start = 1'b0;
      rate = 2'b00; out_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Rate 1/2.
      load_bits(2'b00, 4, 32'b1011);
      drain(1'b0, 100);
      compare_got("t1_r12", 32'b11010001, 8);

      // Rate 3/4, plus a fifth bit offered with a different rate and no frame
      // start: the rate stays 3/4 and phase 1 keeps only A.
      load_bits(2'b10, 4, 32'b1011);
      push_bit(1'b0, 1'b0, 2'b00);
      drain(1'b0, 100);
      compare_got("t2_r34", 32'b1100011, 7);

      load_bits(2'b01, 4, 32'b1011);
      drain(1'b0, 100);
      compare_got("t3_r23", 32'b110000, 6);

      load_bits(2'b11, 4, 32'b1011);
      drain(1'b0, 100);
      compare_got("t3_r11", 32'b11010001, 8);

      // Backpressure mid-stream.
      load_bits(2'b00, 4, 32'b1011);
      repeat (3) step(1'b1, 1'b1);
      repeat (5) step(1'b1, 1'b0);
      drain(1'b0, 100);
      compare_got("t4_bp", 32'b11010001, 8);

      // Reset after two accepted bits.
      load_bits(2'b00, 4, 32'b1011);
      repeat (3) step(1'b1, 1'b1);
      chk("t5_src_left", 32'(src.size()), 32'd2);
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      src.delete(); pend.delete(); got.delete();
      @(negedge clk);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      load_bits(2'b00, 4, 32'b1011);
      drain(1'b0, 100);
      compare_got("t5_fresh", 32'b11010001, 8);

      // Random frames with random valid/ready gaps.
      for (int f = 0; f < 10; f++) begin
         r = 2'($urandom);
         n = $urandom_range(3, 24);
         for (int i = 0; i < n; i++) push_bit(1'($urandom), i == 0, (i == 0) ? r : 2'($urandom));
         drain(1'b1, 2000);
         got.delete();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
